sort3_serializer: RTL and testbench

SORT3_SERIALIZER -- requirements
Module: sort3_serializer

---
 rtl/sort3_serializer.sv | 97 +++++++++
 tb/tb_sort3_serializer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sort3_serializer.sv
// Accepts a signed triple, stable-sorts it into three slots, and emits the
// values one per handshake in descending or ascending order.
module sort3_serializer #(
    parameter int W          = 14,
    parameter bit DESCENDING = 1'b1
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    input  logic signed [W-1:0] i_c,
    input  logic                i_valid,
    output logic                o_ready,
    output logic signed [W-1:0] o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [1:0]          o_idx,
    output logic                o_last
);

    typedef enum logic [1:0] {IDLE, EMIT0, EMIT1, EMIT2} state_t;

    state_t              r_state, w_next;
    logic signed [W-1:0] r_slot [3];
    logic signed [W-1:0] w_srt  [3];
    logic [1:0]          w_pa, w_pb, w_pc;
    logic                w_in_xfer, w_out_xfer;

    // Descending rank; ties resolve earlier input first (A, B, C).
    assign w_pa = {1'b0, (i_b >  i_a)} + {1'b0, (i_c >  i_a)};
    assign w_pb = {1'b0, (i_a >= i_b)} + {1'b0, (i_c >  i_b)};
    assign w_pc = {1'b0, (i_a >= i_c)} + {1'b0, (i_b >= i_c)};

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_srt[k] = '0;
            if (w_pa == 2'(k)) w_srt[k] = i_a;
            if (w_pb == 2'(k)) w_srt[k] = i_b;
            if (w_pc == 2'(k)) w_srt[k] = i_c;
        end
    end

    assign w_in_xfer  = i_valid && o_ready;
    assign w_out_xfer = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            for (int k = 0; k < 3; k++) r_slot[k] <= '0;
        end else begin
            r_state <= w_next;
            if (w_in_xfer)
                for (int k = 0; k < 3; k++) r_slot[k] <= w_srt[k];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_in_xfer)  w_next = EMIT0;
            EMIT0: if (w_out_xfer) w_next = EMIT1;
            EMIT1: if (w_out_xfer) w_next = EMIT2;
            EMIT2: if (w_out_xfer) w_next = w_in_xfer ? EMIT0 : IDLE;
            default:               w_next = IDLE;
        endcase
    end

    // Slots hold descending order; ascending mode just reads them backwards.
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_idx   = 2'd0;
        o_last  = 1'b0;
        o_data  = '0;
        case (r_state)
            IDLE:  o_ready = 1'b1;
            EMIT0: begin
                o_valid = 1'b1;
                o_data  = DESCENDING ? r_slot[0] : r_slot[2];
            end
            EMIT1: begin
                o_valid = 1'b1;
                o_idx   = 2'd1;
                o_data  = r_slot[1];
            end
            EMIT2: begin
                o_ready = i_ready;
                o_valid = 1'b1;
                o_idx   = 2'd2;
                o_last  = 1'b1;
                o_data  = DESCENDING ? r_slot[2] : r_slot[0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sort3_serializer.sv
// Directed bench: a descending and an ascending instance share the same stimulus.
module tb_sort3_serializer;

    localparam int W = 14;

    logic                clk = 1'b0;
    logic                i_rst_n = 1'b0;
    logic signed [W-1:0] i_a = '0, i_b = '0, i_c = '0;
    logic                i_valid = 1'b0, i_ready = 1'b1;
    logic                rdy_d, vld_d, last_d, rdy_u, vld_u, last_u;
    logic signed [W-1:0] data_d, data_u;
    logic [1:0]          idx_d, idx_u;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sort3_serializer #(.W(W), .DESCENDING(1'b1)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_a(i_a), .i_b(i_b), .i_c(i_c),
        .i_valid(i_valid), .o_ready(rdy_d), .o_data(data_d), .o_valid(vld_d),
        .i_ready(i_ready), .o_idx(idx_d), .o_last(last_d));

    sort3_serializer #(.W(W), .DESCENDING(1'b0)) dut_asc (
        .clk(clk), .i_rst_n(i_rst_n), .i_a(i_a), .i_b(i_b), .i_c(i_c),
        .i_valid(i_valid), .o_ready(rdy_u), .o_data(data_u), .o_valid(vld_u),
        .i_ready(i_ready), .o_idx(idx_u), .o_last(last_u));

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input int c);
        i_a = W'(a); i_b = W'(b); i_c = W'(c);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".vld"},  vld_d,  0);
        chk({tag, ".data"}, data_d, 0);
        chk({tag, ".idx"},  idx_d,  0);
        chk({tag, ".last"}, last_d, 0);
        chk({tag, ".rdy"},  rdy_d,  1);
        chk({tag, ".vldu"}, vld_u,  0);
        chk({tag, ".datu"}, data_u, 0);
    endtask

    // Checks one emitted beat at rank i on both instances.
    task automatic chk_beat(input string tag, input int i, input int ed, input int eu);
        chk($sformatf("%s[%0d].vld", tag, i),  vld_d,  1);
        chk($sformatf("%s[%0d].data", tag, i), data_d, ed);
        chk($sformatf("%s[%0d].idx", tag, i),  idx_d,  i);
        chk($sformatf("%s[%0d].last", tag, i), last_d, (i == 2) ? 1 : 0);
        chk($sformatf("%s[%0d].datu", tag, i), data_u, eu);
        chk($sformatf("%s[%0d].idxu", tag, i), idx_u,  i);
    endtask

    task automatic expect3(input string tag, input int e0, input int e1, input int e2);
        int e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int i = 0; i < 3; i++) begin
            chk_beat(tag, i, e[i], e[2-i]);
            tick();
        end
    endtask

    initial begin
        tick(); tick();
        i_rst_n = 1'b1;
        chk_idle("reset");

        send(5, -3, 100);
        expect3("basic", 100, 5, -3);
        chk_idle("basic.end");

        send(7, 7, 7);
        expect3("ties", 7, 7, 7);

        send(-8192, 8191, 0);
        expect3("range", 8191, 0, -8192);

        send(4, 4, -4);
        expect3("tie2", 4, 4, -4);
        chk_idle("tie2.end");

        // Backpressure in EMIT1 while a new triple is offered.
        send(1, 2, 3);
        chk_beat("bp", 0, 3, 1);
        tick();
        i_ready = 1'b0;
        i_a = W'(9); i_b = W'(9); i_c = W'(9); i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp.hold%0d.rdy", k), rdy_d, 0);
            chk_beat($sformatf("bp.hold%0d", k), 1, 2, 2);
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk_beat("bp", 1, 2, 2);
        tick();
        chk_beat("bp", 2, 1, 3);
        tick();
        chk_idle("bp.end");

        // Streaming: second triple taken in the EMIT2 cycle.
        i_a = W'(10); i_b = W'(-20); i_c = W'(30); i_valid = 1'b1;
        tick();
        i_a = W'(-1); i_b = W'(-2); i_c = W'(-3);
        chk_beat("strm", 0, 30, -20);
        tick();
        chk_beat("strm", 1, 10, 10);
        tick();
        chk_beat("strm", 2, -20, 30);
        chk("strm.rdy_e2", rdy_d, 1);
        tick();
        i_valid = 1'b0;
        expect3("strm2", -1, -2, -3);
        chk_idle("strm.end");

        // Reset in EMIT1.
        send(4, 5, 6);
        chk_beat("rst", 0, 6, 4);
        tick();
        chk_beat("rst", 1, 5, 5);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        chk_idle("rst.after");
        send(0, -1, 1);
        expect3("rst.new", 1, 0, -1);
        chk_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
